// File: rtl/lbist_test_sequencer.sv
// lbist_test_sequencer: sequences SA then TD LBIST patterns, tracks faults and triggers diagnosis
module lbist_test_sequencer #(
  parameter int SYSTOLIC_SIZE         = 8,
  parameter int SA_TEST_PATTERN_DEPTH = 8,
  parameter int TD_TEST_PATTERN_DEPTH = 16,
  parameter int CNT_WIDTH             = $clog2(TD_TEST_PATTERN_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mismatch,
  output logic                 test_type,
  output logic [CNT_WIDTH-1:0] test_counter,
  output logic [1:0]           td_pe_select,
  output logic                 scan_en,
  output logic                 capture_w,
  output logic                 compare_en,
  output logic                 diag_start,
  output logic                 detection_en,
  output logic                 busy,
  output logic                 done,
  output logic                 test_result
);
  localparam int SW = SYSTOLIC_SIZE > 1 ? $clog2(SYSTOLIC_SIZE) : 1;
  typedef enum logic [2:0] {IDLE, SHIFT, LAUNCH, CAPTURE, COMPARE, DIAG_PULSE, DIAG_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [SW-1:0] shift_cnt, shift_cnt_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic [1:0] pe_n;
  logic type_n, fault_seen, fault_n, result_n, shift_last;
  assign shift_last   = shift_cnt == SW'(SYSTOLIC_SIZE - 1);
  assign scan_en      = state == SHIFT;
  assign capture_w    = state == LAUNCH || state == CAPTURE;
  assign compare_en   = state == COMPARE;
  assign diag_start   = state == DIAG_PULSE;
  assign detection_en = state == DIAG_WAIT;
  assign done         = state == DONE;
  assign busy         = state != IDLE && state != DONE;
  // state and sequencing registers; test_result resets to pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_cnt    <= '0;
      test_counter <= '0;
      td_pe_select <= '0;
      test_type    <= 1'b0;
      fault_seen   <= 1'b0;
      test_result  <= 1'b1;
    end else begin
      state        <= state_n;
      shift_cnt    <= shift_cnt_n;
      test_counter <= cnt_n;
      td_pe_select <= pe_n;
      test_type    <= type_n;
      fault_seen   <= fault_n;
      test_result  <= result_n;
    end
  end
  // next-state: shift/capture/compare loop per pattern, abort overrides everything
  always_comb begin
    state_n     = state;
    shift_cnt_n = shift_cnt;
    cnt_n       = test_counter;
    pe_n        = td_pe_select;
    type_n      = test_type;
    fault_n     = fault_seen;
    case (state)
      IDLE: if (start) begin
        fault_n     = 1'b0;
        cnt_n       = '0;
        pe_n        = '0;
        type_n      = 1'b0;
        shift_cnt_n = '0;
        state_n     = SHIFT;
      end
      SHIFT, DIAG_WAIT: begin
        shift_cnt_n = shift_last ? '0 : shift_cnt + 1'b1;
        if (shift_last) state_n = state == DIAG_WAIT ? DONE : test_type ? LAUNCH : CAPTURE;
      end
      LAUNCH:  state_n = CAPTURE;
      CAPTURE: state_n = COMPARE;
      COMPARE: begin
        fault_n = fault_seen | mismatch;
        state_n = SHIFT;
        if (!test_type) begin
          if (test_counter < CNT_WIDTH'(SA_TEST_PATTERN_DEPTH - 1)) cnt_n = test_counter + 1'b1;
          else begin
            type_n = 1'b1;
            cnt_n  = '0;
          end
        end else if (td_pe_select != 2'd3) pe_n = td_pe_select + 1'b1;
        else begin
          pe_n = '0;
          if (test_counter < CNT_WIDTH'(TD_TEST_PATTERN_DEPTH - 1)) cnt_n = test_counter + 1'b1;
          else state_n = fault_n ? DIAG_PULSE : DONE;
        end
      end
      DIAG_PULSE: begin
        shift_cnt_n = '0;
        state_n     = DIAG_WAIT;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n     = IDLE;
      shift_cnt_n = '0;
    end
    result_n = state_n == DONE && state != DONE ? ~fault_n : test_result;
  end
endmodule

// File: tb/tb_lbist_test_sequencer.sv
// tb_lbist_test_sequencer: directed checks of LBIST sequencing, fault/diagnosis, abort and reset
module tb_lbist_test_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, mismatch = 1'b0;
  logic test_type, scan_en, capture_w, compare_en, diag_start, detection_en, busy, done, test_result;
  logic [3:0] test_counter;
  logic [1:0] td_pe_select;
  int pass_cnt = 0, total = 0;
  int cyc, first_tt, done_cyc, diag_cyc, diag_cnt, det_cnt, sa_cmp, td_cmp, seq_err, bad_runs, scan_runs, scan_cyc, run;
  logic res_after, busy_after;

  lbist_test_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mismatch(mismatch),
    .test_type(test_type), .test_counter(test_counter), .td_pe_select(td_pe_select),
    .scan_en(scan_en), .capture_w(capture_w), .compare_en(compare_en), .diag_start(diag_start),
    .detection_en(detection_en), .busy(busy), .done(done), .test_result(test_result)
  );

  always #5 clk = ~clk;

  task automatic run_seq(input int fault_at, input bit stray, input bit hold, input int stop_at);
    int idx;
    first_tt = -1; done_cyc = -1; diag_cyc = -1; diag_cnt = 0; det_cnt = 0; sa_cmp = 0; td_cmp = 0;
    seq_err = 0; bad_runs = 0; scan_runs = 0; scan_cyc = 0; run = 0; res_after = 1'bx; busy_after = 1'bx;
    start = 1'b1;
    mismatch = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      cyc = c;
      if (!hold) start = 1'b0;
      if (test_type && first_tt < 0) first_tt = c;
      if (scan_en) begin run++; scan_cyc++; end
      else if (run > 0) begin scan_runs++; if (run != 8) bad_runs++; run = 0; end
      idx = sa_cmp + td_cmp;
      mismatch = (compare_en && idx == fault_at) || (stray && scan_en);
      if (compare_en) begin
        if (test_type) begin
          if (td_pe_select !== 2'(td_cmp % 4) || test_counter !== 4'(td_cmp / 4)) seq_err++;
          td_cmp++;
        end else begin
          if (test_counter !== 4'(sa_cmp) || td_pe_select !== 2'd0) seq_err++;
          sa_cmp++;
        end
      end
      if (diag_start) begin diag_cnt++; diag_cyc = c; end
      if (detection_en) det_cnt++;
      if (done) begin
        done_cyc = c;
        @(negedge clk);
        mismatch = 1'b0;
        cyc = c + 1;
        res_after = test_result;
        busy_after = busy;
        return;
      end
      if (c == stop_at) return;
    end
    mismatch = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total++; if (test_result !== 1'b1) $display("FAIL reset_result: got %b expected 1", test_result); else pass_cnt++;
    total++; if ({scan_en, capture_w, compare_en, diag_start, detection_en, done} !== 6'b0) $display("FAIL reset_strobes: got %b expected 000000", {scan_en, capture_w, compare_en, diag_start, detection_en, done}); else pass_cnt++;
    total++; if ({test_type, test_counter, td_pe_select} !== 7'b0) $display("FAIL reset_counters: got %b expected 0", {test_type, test_counter, td_pe_select}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL idle_no_start_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_clean_run();
    run_seq(-1, 1'b0, 1'b0, 0);
    total++; if (first_tt !== 81) $display("FAIL clean_type_rise: got %0d expected 81", first_tt); else pass_cnt++;
    total++; if (done_cyc !== 785) $display("FAIL clean_done_cycle: got %0d expected 785", done_cyc); else pass_cnt++;
    total++; if (res_after !== 1'b1) $display("FAIL clean_result: got %b expected 1", res_after); else pass_cnt++;
    total++; if (diag_cnt !== 0) $display("FAIL clean_diag: got %0d expected 0", diag_cnt); else pass_cnt++;
    total++; if (busy_after !== 1'b0) $display("FAIL clean_idle_after: got %b expected 0", busy_after); else pass_cnt++;
  endtask

  task automatic test_td_sequencing();
    run_seq(-1, 1'b0, 1'b0, 0);
    total++; if (sa_cmp !== 8) $display("FAIL sa_compare_count: got %0d expected 8", sa_cmp); else pass_cnt++;
    total++; if (td_cmp !== 64) $display("FAIL td_compare_count: got %0d expected 64", td_cmp); else pass_cnt++;
    total++; if (seq_err !== 0) $display("FAIL td_index_order: got %0d bad strobes expected 0", seq_err); else pass_cnt++;
    total++; if (scan_runs !== 72 || bad_runs !== 0) $display("FAIL scan_windows: got %0d runs %0d bad expected 72 runs 0 bad", scan_runs, bad_runs); else pass_cnt++;
    total++; if (scan_cyc !== 576) $display("FAIL scan_cycles: got %0d expected 576", scan_cyc); else pass_cnt++;
  endtask

  task automatic test_td_fault();
    run_seq(71, 1'b0, 1'b0, 0);
    total++; if (diag_cyc !== 785 || diag_cnt !== 1) $display("FAIL td_fault_diag: got cycle %0d count %0d expected 785 1", diag_cyc, diag_cnt); else pass_cnt++;
    total++; if (done_cyc !== 794) $display("FAIL td_fault_done: got %0d expected 794", done_cyc); else pass_cnt++;
    total++; if (res_after !== 1'b0) $display("FAIL td_fault_result: got %b expected 0", res_after); else pass_cnt++;
  endtask

  task automatic test_stray_mismatch();
    run_seq(-1, 1'b1, 1'b0, 0);
    total++; if (diag_cnt !== 0) $display("FAIL stray_diag: got %0d expected 0", diag_cnt); else pass_cnt++;
    total++; if (done_cyc !== 785) $display("FAIL stray_done: got %0d expected 785", done_cyc); else pass_cnt++;
    total++; if (res_after !== 1'b1) $display("FAIL stray_result: got %b expected 1", res_after); else pass_cnt++;
  endtask

  task automatic test_sa_fault();
    run_seq(3, 1'b0, 1'b0, 0);
    total++; if (diag_cyc !== 785 || diag_cnt !== 1) $display("FAIL sa_fault_diag: got cycle %0d count %0d expected 785 1", diag_cyc, diag_cnt); else pass_cnt++;
    total++; if (det_cnt !== 8) $display("FAIL sa_fault_detection: got %0d expected 8", det_cnt); else pass_cnt++;
    total++; if (done_cyc !== 794) $display("FAIL sa_fault_done: got %0d expected 794", done_cyc); else pass_cnt++;
    total++; if (res_after !== 1'b0) $display("FAIL sa_fault_result: got %b expected 0", res_after); else pass_cnt++;
  endtask

  task automatic test_abort();
    int seen;
    run_seq(-1, 1'b0, 1'b0, 100);
    abort = 1'b1;
    @(negedge clk);
    total++; if ({scan_en, capture_w, compare_en, diag_start, detection_en} !== 5'b0) $display("FAIL abort_strobes: got %b expected 00000", {scan_en, capture_w, compare_en, diag_start, detection_en}); else pass_cnt++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_busy_done: got %b%b expected 00", busy, done); else pass_cnt++;
    total++; if (test_result !== 1'b0) $display("FAIL abort_result_held: got %b expected 0", test_result); else pass_cnt++;
    abort = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (done || busy) seen++; end
    total++; if (seen !== 0) $display("FAIL abort_stays_idle: got %0d active cycles expected 0", seen); else pass_cnt++;
    run_seq(-1, 1'b0, 1'b0, 0);
    total++; if (done_cyc !== 785 || res_after !== 1'b1) $display("FAIL abort_restart: got done %0d result %b expected 785 1", done_cyc, res_after); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    run_seq(3, 1'b0, 1'b0, 0);
    run_seq(-1, 1'b0, 1'b0, 300);
    rst_n = 1'b0;
    #1;
    total++; if (test_result !== 1'b1) $display("FAIL midreset_result: got %b expected 1", test_result); else pass_cnt++;
    total++; if ({busy, scan_en, capture_w, compare_en, done} !== 5'b0) $display("FAIL midreset_strobes: got %b expected 00000", {busy, scan_en, capture_w, compare_en, done}); else pass_cnt++;
    total++; if ({test_type, test_counter, td_pe_select} !== 7'b0) $display("FAIL midreset_counters: got %b expected 0", {test_type, test_counter, td_pe_select}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    run_seq(-1, 1'b0, 1'b0, 0);
    total++; if (done_cyc !== 785 || res_after !== 1'b1) $display("FAIL midreset_restart: got done %0d result %b expected 785 1", done_cyc, res_after); else pass_cnt++;
  endtask

  task automatic test_start_held();
    run_seq(-1, 1'b0, 1'b1, 0);
    total++; if (done_cyc !== 785 || busy_after !== 1'b0) $display("FAIL held_first_run: got done %0d busy %b expected 785 0", done_cyc, busy_after); else pass_cnt++;
    @(negedge clk);
    total++; if (busy !== 1'b1 || scan_en !== 1'b1) $display("FAIL held_relaunch: got busy %b scan %b expected 1 1", busy, scan_en); else pass_cnt++;
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL held_abort: got %b expected 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_td_sequencing();
    test_td_fault();
    test_stray_mismatch();
    test_sa_fault();
    test_abort();
    test_reset_mid();
    test_start_held();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/lbist_test_sequencer.md
Name: lbist_test_sequencer

Overview:
- Sequences LBIST on the systolic array: runs all stuck-at (SA) patterns, then all transition-delay (TD) patterns, then optionally the diagnostic loop chains.
- Drives the pattern index and test type to eNVM, scan enable and weight-capture strobe to the array, and compare strobe to the hybrid_bist comparator.
- Accumulates the comparator mismatch flag into a sticky fault bit, reports pass/fail, and triggers diagnosis only when a fault was seen.

Parameters:
- SYSTOLIC_SIZE, 8, array dimension; scan shift length in cycles.
- SA_TEST_PATTERN_DEPTH, 8, number of SA patterns.
- TD_TEST_PATTERN_DEPTH, 16, number of TD patterns.
- CNT_WIDTH, $clog2(TD_TEST_PATTERN_DEPTH), pattern index width (TD depth >= SA depth).

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled only in IDLE
- abort  in  1  synchronous; returns to IDLE next cycle
- mismatch  in  1  comparator result, valid while compare_en=1
- test_type  out  1  0 = SA, 1 = TD
- test_counter  out  CNT_WIDTH  current eNVM pattern index
- td_pe_select  out  2  TD PE group (0-3); 0 during SA
- scan_en  out  1  array scan shift enable
- capture_w  out  1  one-cycle weight/launch capture strobe
- compare_en  out  1  one-cycle comparator strobe
- diag_start  out  1  one-cycle pulse to Diagnostic_loop_chains start_en
- detection_en  out  1  eNVM fault-log write window
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse on entry to DONE
- test_result  out  1  1 = pass; held until next start

Behaviour:
- Reset values: all outputs 0, except test_result = 1. State = IDLE; shift_cnt, test_counter, td_pe_select and fault_seen = 0.
- States: IDLE, SHIFT, LAUNCH, CAPTURE, COMPARE, DIAG_PULSE, DIAG_WAIT, DONE.
- IDLE, start=1: clear fault_seen, test_counter, td_pe_select and test_type; go to SHIFT next cycle.
- SHIFT: scan_en=1 for exactly SYSTOLIC_SIZE cycles (shift_cnt 0..N-1).
  - SA: shift -> CAPTURE.
  - TD: shift -> LAUNCH.
- LAUNCH (TD only): one cycle, capture_w=1 (launch edge).
- CAPTURE: one cycle, capture_w=1.
- COMPARE: one cycle, compare_en=1; fault_seen |= mismatch.
- Advance after COMPARE:
  - SA: if test_counter < SA_DEPTH-1, increment it and go to SHIFT. Otherwise set test_type=1, test_counter=0, then SHIFT.
  - TD: if td_pe_select < 3, increment it and go to SHIFT. Otherwise td_pe_select=0; if test_counter < TD_DEPTH-1, increment it and go to SHIFT, else go to end-of-test.
- End-of-test: fault_seen=1 -> DIAG_PULSE; fault_seen=0 -> DONE.
- DIAG_PULSE: diag_start=1 for one cycle -> DIAG_WAIT.
- DIAG_WAIT: detection_en=1 for SYSTOLIC_SIZE cycles -> DONE.
- DONE: done=1 for one cycle; test_result = ~fault_seen is registered here. Go to IDLE next cycle; start is ignored during DONE.
- Cycle cost per pattern:
  - SA: N+2 cycles.
  - TD: N+3 cycles per pe_select, 4 pe_selects per pattern.
- Sequence length, N=8 defaults:
  - SA total: 80 cycles; TD total: 704 cycles.
  - Pass: done at cycle 785 after the start sample cycle.
  - Fail: done at cycle 794 after the start sample cycle (+9 for diagnosis).
- abort has priority over every transition:
  - Next cycle: state IDLE; scan_en, capture_w, compare_en, diag_start and detection_en are all 0.
  - test_result unchanged; done not pulsed.
- Asynchronous reset mid-operation forces the reset values immediately.
- mismatch outside COMPARE is ignored.
- start held high continuously re-launches a test from IDLE after each DONE.
- Counters never wrap: test_counter maxes at the depth-1 of the current phase.

Test Plan:
- Clean run: start pulse, mismatch=0 -> test_type rises after 80 cycles; done at cycle 785; test_result=1; diag_start never asserted.
- SA fault: mismatch=1 at SA pattern 3 compare -> diag_start pulse at cycle 785; detection_en high for 8 cycles; done at 794; test_result=0.
- TD sequencing: monitor compare_en strobes in TD phase -> td_pe_select cycles 0,1,2,3 per pattern; test_counter steps 0..15; 64 TD compare strobes; scan_en high exactly 8 cycles per TD iteration.
- Stray mismatch: mismatch=1 during SHIFT only -> test_result=1, no diagnosis.
- Abort: abort asserted at cycle 100 -> next cycle all strobes 0, busy=0, no done; fresh start completes normally.
- Reset mid-test: rst_n low at cycle 300 -> outputs immediately at reset values, test_result=1; restart completes in 785 cycles.
